// File: rtl/regbank_pkg.sv
// Shared widths, writer identifiers and write-payload type for the register-bank controller.
package regbank_pkg;
  localparam int unsigned WIDTH = 15;
  localparam int unsigned NREG  = 8;
  localparam int unsigned AW    = 3;

  typedef enum logic {
    WR_A = 1'b0,
    WR_B = 1'b1
  } writer_e;

  typedef struct packed {
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
  } wr_req_t;
endpackage

// File: rtl/regbank_if.sv
// Two-writer req/gnt write handshake into the register bank.
interface regbank_if
  import regbank_pkg::*;
();
  logic             req_a;
  logic [AW-1:0]    addr_a;
  logic [WIDTH-1:0] data_a;
  logic             gnt_a;
  logic             req_b;
  logic [AW-1:0]    addr_b;
  logic [WIDTH-1:0] data_b;
  logic             gnt_b;

  modport master (
    output req_a, addr_a, data_a, req_b, addr_b, data_b,
    input  gnt_a, gnt_b
  );

  modport slave (
    input  req_a, addr_a, data_a, req_b, addr_b, data_b,
    output gnt_a, gnt_b
  );
endinterface

// File: rtl/onehot_dec.sv
// Address to one-hot select decoder with enable.
module onehot_dec
  import regbank_pkg::*;
#(
  parameter int unsigned DAW = AW,
  parameter int unsigned DN  = NREG
) (
  input  logic           en,
  input  logic [DAW-1:0] addr,
  output logic [DN-1:0]  dec
);
  always_comb begin
    dec = '0;
    if (en) dec[addr] = 1'b1;
  end
endmodule

// File: rtl/regbank_ctrl.sv
// Round-robin write arbiter, one-cycle write stage, read decode and
// read-after-write forwarding for the 8 x 15 register bank.
module regbank_ctrl
  import regbank_pkg::*;
#(
  parameter bit ZERO_REG = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  regbank_if.slave         wr,
  input  logic             rd_en1,
  input  logic [AW-1:0]    rd_addr1,
  input  logic             rd_en2,
  input  logic [AW-1:0]    rd_addr2,
  output logic [NREG-1:0]  ws,
  output logic [WIDTH-1:0] wd,
  output logic [NREG-1:0]  rs1,
  output logic [NREG-1:0]  rs2,
  output logic             fwd1,
  output logic             fwd2,
  output logic [WIDTH-1:0] fwd_data
);
  writer_e last_q, last_d;
  logic    pend_v_q, pend_v_d;
  wr_req_t pend_q, pend_d;
  logic    zero_hit;
  logic    ws_en;

  // Grants depend only on requests and last winner; held low in reset.
  assign wr.gnt_a = rst_n & wr.req_a & (~wr.req_b | (last_q == WR_B));
  assign wr.gnt_b = rst_n & wr.req_b & (~wr.req_a | (last_q == WR_A));

  always_comb begin
    last_d   = last_q;
    pend_v_d = 1'b0;
    pend_d   = pend_q;
    if (wr.gnt_a) begin
      last_d   = WR_A;
      pend_v_d = 1'b1;
      pend_d   = '{addr: wr.addr_a, data: wr.data_a};
    end else if (wr.gnt_b) begin
      last_d   = WR_B;
      pend_v_d = 1'b1;
      pend_d   = '{addr: wr.addr_b, data: wr.data_b};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q   <= WR_B;
      pend_v_q <= 1'b0;
      pend_q   <= '0;
    end else begin
      last_q   <= last_d;
      pend_v_q <= pend_v_d;
      pend_q   <= pend_d;
    end
  end

  // Writes to the hardwired zero cell complete but never strobe or forward.
  assign zero_hit = ZERO_REG && (pend_q.addr == '0);
  assign ws_en    = pend_v_q & ~zero_hit;

  onehot_dec u_ws_dec  (.en(ws_en),  .addr(pend_q.addr), .dec(ws));
  onehot_dec u_rs1_dec (.en(rd_en1), .addr(rd_addr1),    .dec(rs1));
  onehot_dec u_rs2_dec (.en(rd_en2), .addr(rd_addr2),    .dec(rs2));

  assign wd       = pend_q.data;
  assign fwd_data = pend_q.data;
  assign fwd1     = rd_en1 & ws_en & (rd_addr1 == pend_q.addr);
  assign fwd2     = rd_en2 & ws_en & (rd_addr2 == pend_q.addr);
endmodule

// File: tb/tb_regbank_ctrl.sv
// Scoreboard bench for regbank_ctrl with a behavioural model of the sram cells.
module tb_regbank_ctrl;
  import regbank_pkg::*;

  typedef struct packed {
    logic [NREG-1:0]  ws;
    logic [WIDTH-1:0] wd;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  regbank_if bus ();
  logic             rd_en1, rd_en2;
  logic [AW-1:0]    rd_addr1, rd_addr2;
  logic [NREG-1:0]  ws, rs1, rs2;
  logic [WIDTH-1:0] wd, fwd_data;
  logic             fwd1, fwd2;

  regbank_ctrl #(.ZERO_REG(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .wr(bus.slave),
    .rd_en1(rd_en1), .rd_addr1(rd_addr1), .rd_en2(rd_en2), .rd_addr2(rd_addr2),
    .ws(ws), .wd(wd), .rs1(rs1), .rs2(rs2),
    .fwd1(fwd1), .fwd2(fwd2), .fwd_data(fwd_data)
  );

  // sram_1x15 cell model: capture wd on a strobed edge, read via one-hot select
  logic [WIDTH-1:0] mem [NREG];
  logic [WIDTH-1:0] rd1, rd2;
  always @(posedge clk) begin
    for (int i = 0; i < NREG; i++) if (ws[i]) mem[i] <= wd;
  end
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    for (int i = 0; i < NREG; i++) begin
      if (rs1[i]) rd1 = rd1 | mem[i];
      if (rs2[i]) rd2 = rd2 | mem[i];
    end
  end

  int      tests = 0;
  int      fails = 0;
  exp_t    sb[$];
  writer_e m_last = WR_B;
  logic    exp_ga, exp_gb;

  function automatic logic [NREG-1:0] ws_of(input logic [AW-1:0] a);
    logic [NREG-1:0] v;
    v = '0;
    if (a != '0) v[a] = 1'b1;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drives both writers, predicts grants and queues the expected write.
  task automatic drive(input logic ra, input logic [AW-1:0] aa, input logic [WIDTH-1:0] da,
                       input logic rb, input logic [AW-1:0] ab, input logic [WIDTH-1:0] db);
    exp_t e;
    bus.req_a = ra; bus.addr_a = aa; bus.data_a = da;
    bus.req_b = rb; bus.addr_b = ab; bus.data_b = db;
    #1;
    exp_ga = rst_n & ra & (!rb | (m_last == WR_B));
    exp_gb = rst_n & rb & (!ra | (m_last == WR_A));
    if (exp_ga) begin
      e.ws = ws_of(aa); e.wd = da; sb.push_back(e); m_last = WR_A;
    end else if (exp_gb) begin
      e.ws = ws_of(ab); e.wd = db; sb.push_back(e); m_last = WR_B;
    end
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0;
    rd_en1 = 1'b1; rd_addr1 = '0; rd_en2 = 1'b0; rd_addr2 = '0;
    drive(1'b1, 3'd7, 15'h1234, 1'b1, 3'd4, 15'h4321);
    tick();
    tests++; if (bus.gnt_a !== 1'b0) begin fails++; $display("FAIL rst_gnt_a got %b want 0", bus.gnt_a); end
    tests++; if (bus.gnt_b !== 1'b0) begin fails++; $display("FAIL rst_gnt_b got %b want 0", bus.gnt_b); end
    tests++; if (ws !== '0) begin fails++; $display("FAIL rst_ws got %h want 0", ws); end
    tests++; if (wd !== '0) begin fails++; $display("FAIL rst_wd got %h want 0", wd); end
    tests++; if (fwd1 !== 1'b0) begin fails++; $display("FAIL rst_fwd1 got %b want 0", fwd1); end
    tests++; if (rs1 !== 8'h01) begin fails++; $display("FAIL rst_rs1 got %h want 01", rs1); end
    rst_n = 1'b1;
    m_last = WR_B;
    drive(1'b1, 3'd7, 15'h1234, 1'b1, 3'd4, 15'h4321);
    tests++; if (bus.gnt_a !== 1'b1 || bus.gnt_b !== 1'b0) begin
      fails++; $display("FAIL first_gnt got a=%b b=%b want a=1 b=0", bus.gnt_a, bus.gnt_b);
    end
    tick();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    e = sb.pop_front();
    tests++; if (ws !== e.ws || wd !== e.wd) begin
      fails++; $display("FAIL first_write got ws=%h wd=%h want ws=%h wd=%h", ws, wd, e.ws, e.wd);
    end
    rd_en1 = 1'b0;
    tick();
  endtask

  task automatic test_single_write();
    exp_t e;
    drive(1'b1, 3'd3, 15'h0001, 1'b0, '0, '0);
    tests++; if (bus.gnt_a !== exp_ga) begin fails++; $display("FAIL sw_gnt got %b want %b", bus.gnt_a, exp_ga); end
    tick();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    e = sb.pop_front();
    tests++; if (ws !== 8'b0000_1000 || ws !== e.ws) begin fails++; $display("FAIL sw_ws got %h want 08", ws); end
    tests++; if (wd !== e.wd) begin fails++; $display("FAIL sw_wd got %h want %h", wd, e.wd); end
    tick();
    rd_en1 = 1'b1; rd_addr1 = 3'd3;
    #1;
    tests++; if (rd1 !== 15'h0001) begin fails++; $display("FAIL sw_rd1 got %h want 0001", rd1); end
    tests++; if (fwd1 !== 1'b0) begin fails++; $display("FAIL sw_fwd1 got %b want 0", fwd1); end
    tests++; if (ws !== '0) begin fails++; $display("FAIL sw_ws_idle got %h want 0", ws); end
    rd_en1 = 1'b0;
  endtask

  task automatic test_contention();
    exp_t e;
    logic prev_a;
    prev_a = (m_last == WR_A);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 3'd1, 15'h0011, 1'b1, 3'd2, 15'h0022);
      tests++; if (bus.gnt_a !== exp_ga || bus.gnt_b !== exp_gb) begin
        fails++; $display("FAIL cont_gnt[%0d] got a=%b b=%b want a=%b b=%b", i, bus.gnt_a, bus.gnt_b, exp_ga, exp_gb);
      end
      tests++; if (bus.gnt_a === prev_a) begin
        fails++; $display("FAIL cont_alt[%0d] got a=%b want %b", i, bus.gnt_a, !prev_a);
      end
      prev_a = bus.gnt_a;
      tick();
      if (sb.size() == 0) begin
        tests++; fails++; $display("FAIL cont_sb[%0d] got empty want entry", i);
      end else begin
        e = sb.pop_front();
        tests++; if (ws !== e.ws || wd !== e.wd) begin
          fails++; $display("FAIL cont_ws[%0d] got ws=%h wd=%h want ws=%h wd=%h", i, ws, wd, e.ws, e.wd);
        end
      end
    end
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    tick();
  endtask

  task automatic test_forward();
    exp_t e;
    rd_en1 = 1'b1; rd_addr1 = 3'd5; rd_en2 = 1'b1; rd_addr2 = 3'd5;
    drive(1'b0, '0, '0, 1'b1, 3'd5, 15'h7FFF);
    tests++; if (bus.gnt_b !== 1'b1) begin fails++; $display("FAIL fwd_gnt_b got %b want 1", bus.gnt_b); end
    tick();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    e = sb.pop_front();
    tests++; if (ws !== e.ws) begin fails++; $display("FAIL fwd_ws got %h want %h", ws, e.ws); end
    tests++; if (fwd1 !== 1'b1 || fwd2 !== 1'b1) begin fails++; $display("FAIL fwd_flags got %b%b want 11", fwd1, fwd2); end
    tests++; if (fwd_data !== 15'h7FFF) begin fails++; $display("FAIL fwd_data got %h want 7fff", fwd_data); end
    tick();
    tests++; if (fwd1 !== 1'b0 || fwd2 !== 1'b0) begin fails++; $display("FAIL fwd_clear got %b%b want 00", fwd1, fwd2); end
    tests++; if (rd1 !== 15'h7FFF || rd2 !== 15'h7FFF) begin fails++; $display("FAIL fwd_cell got %h/%h want 7fff", rd1, rd2); end
    rd_addr2 = 3'd2;
    #1;
    tests++; if (rd2 !== 15'h0022) begin fails++; $display("FAIL rd2_addr2 got %h want 0022", rd2); end
    rd_en1 = 1'b0; rd_en2 = 1'b0;
  endtask

  task automatic test_zero_reg();
    exp_t e;
    rd_en1 = 1'b1; rd_addr1 = 3'd0;
    drive(1'b1, 3'd0, 15'h0002, 1'b0, '0, '0);
    tests++; if (bus.gnt_a !== 1'b1) begin fails++; $display("FAIL zr_gnt got %b want 1", bus.gnt_a); end
    tick();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    e = sb.pop_front();
    tests++; if (ws !== 8'h00 || ws !== e.ws) begin fails++; $display("FAIL zr_ws got %h want 00", ws); end
    tests++; if (fwd1 !== 1'b0) begin fails++; $display("FAIL zr_fwd1 got %b want 0", fwd1); end
    rd_en1 = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_write();
    exp_t e;
    drive(1'b1, 3'd6, 15'h0AAA, 1'b0, '0, '0);
    tick();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    e = sb.pop_front();
    tests++; if (ws !== e.ws || wd !== e.wd) begin fails++; $display("FAIL rm_pre got ws=%h wd=%h want ws=%h wd=%h", ws, wd, e.ws, e.wd); end
    tick();
    drive(1'b1, 3'd6, 15'h0555, 1'b0, '0, '0);
    tick();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    e = sb.pop_front();
    tests++; if (ws !== 8'h40 || ws !== e.ws) begin fails++; $display("FAIL rm_ws_live got %h want 40", ws); end
    rd_en1 = 1'b1; rd_addr1 = 3'd6;
    rst_n = 1'b0;
    #1;
    m_last = WR_B;
    tests++; if (ws !== '0) begin fails++; $display("FAIL rm_ws_async got %h want 0", ws); end
    tests++; if (wd !== '0 || fwd1 !== 1'b0) begin fails++; $display("FAIL rm_wd_fwd got wd=%h fwd1=%b want 0/0", wd, fwd1); end
    tick();
    rst_n = 1'b1;
    #1;
    tests++; if (rd1 !== 15'h0AAA) begin fails++; $display("FAIL rm_cell got %h want 0aaa", rd1); end
    drive(1'b1, 3'd1, 15'h0111, 1'b1, 3'd2, 15'h0222);
    tests++; if (bus.gnt_a !== 1'b1 || bus.gnt_b !== 1'b0) begin
      fails++; $display("FAIL rm_last got a=%b b=%b want a=1 b=0", bus.gnt_a, bus.gnt_b);
    end
    tick();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    e = sb.pop_front();
    tests++; if (ws !== e.ws || wd !== e.wd) begin fails++; $display("FAIL rm_post got ws=%h wd=%h want ws=%h wd=%h", ws, wd, e.ws, e.wd); end
    rd_en1 = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_contention();
    test_forward();
    test_zero_reg();
    test_reset_mid_write();
    if (sb.size() != 0) begin
      tests++; fails++; $display("FAIL sb_leftover got %0d want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
